mac_accumulator: RTL

- Sequential multiply-accumulate stage that consumes operand pairs and emits dot products.
- Computes each x*y by shift-and-add over N clock cycles.
- Accumulates TERMS consecutive products into one sum, then presents it on a valid/ready output.
- Clocked, handshaked replacement for the untimed repeated-addition product path in the same arithmetic library.

---
 rtl/mac_pkg.sv | 23 ++
 rtl/mac_accumulator_if.sv | 24 ++
 rtl/shift_add_mul.sv | 49 ++++
 rtl/mac_accumulator.sv | 89 ++++++++
 4 files changed

// File: rtl/mac_pkg.sv
// Shared types and defaults for the sequential multiply-accumulate slice.
package mac_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MUL  = 2'd1,
    ACC  = 2'd2,
    OUT  = 2'd3
  } state_t;

  localparam int N_DEF     = 4;
  localparam int ACC_W_DEF = 12;
  localparam int TERMS_DEF = 4;

  // Bits needed to hold values 0..v-1 (0 for v<=1; callers clamp to 1).
  function automatic int clog2(input int v);
    int r;
    r = 0;
    while ((1 << r) < v) r++;
    return r;
  endfunction

endpackage

// File: rtl/mac_accumulator_if.sv
// Operand-in / result-out handshake bundle for mac_accumulator.
interface mac_accumulator_if #(
  parameter int N     = 4,
  parameter int ACC_W = 12
);
  logic             in_valid;
  logic             in_ready;
  logic [N-1:0]     x;
  logic [N-1:0]     y;
  logic             out_valid;
  logic             out_ready;
  logic [ACC_W-1:0] acc_out;
  logic             ovf;

  modport master (
    output in_valid, x, y, out_ready,
    input  in_ready, out_valid, acc_out, ovf
  );

  modport slave (
    input  in_valid, x, y, out_ready,
    output in_ready, out_valid, acc_out, ovf
  );
endinterface

// File: rtl/shift_add_mul.sv
// Unsigned N x N multiplier, one partial product per clock, fixed N-cycle latency.
module shift_add_mul
  import mac_pkg::*;
#(
  parameter int N = N_DEF
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           start,
  input  logic [N-1:0]   x,
  input  logic [N-1:0]   y,
  output logic           busy,
  output logic           done,
  output logic [2*N-1:0] product
);

  localparam int BW = (clog2(N) > 0) ? clog2(N) : 1;
  localparam logic [BW-1:0] LAST_BIT = BW'(N - 1);

  logic [2*N-1:0] mcand;
  logic [N-1:0]   mplier;
  logic [BW-1:0]  bitcnt;

  // No early exit on a zero multiplier so the latency is always exactly N.
  always_ff @(posedge clk) begin
    if (rst) begin
      busy    <= 1'b0;
      mcand   <= '0;
      mplier  <= '0;
      product <= '0;
      bitcnt  <= '0;
    end else if (busy) begin
      if (mplier[0]) product <= product + mcand;
      mcand  <= mcand << 1;
      mplier <= mplier >> 1;
      bitcnt <= bitcnt + BW'(1);
      if (bitcnt == LAST_BIT) busy <= 1'b0;
    end else if (start) begin
      busy    <= 1'b1;
      mcand   <= {{N{1'b0}}, x};
      mplier  <= y;
      product <= '0;
      bitcnt  <= '0;
    end
  end

  assign done = busy && (bitcnt == LAST_BIT);

endmodule

// File: rtl/mac_accumulator.sv
// Accumulates TERMS shift-and-add products into one dot product behind valid/ready.
module mac_accumulator
  import mac_pkg::*;
#(
  parameter int N     = N_DEF,
  parameter int ACC_W = ACC_W_DEF,
  parameter int TERMS = TERMS_DEF
) (
  input  logic           clk,
  input  logic           rst,
  mac_accumulator_if.slave bus
);

  if (ACC_W < 2 * N) begin : g_bad_acc_w
    $error("mac_accumulator: ACC_W must be >= 2*N");
  end
  if (TERMS < 1) begin : g_bad_terms
    $error("mac_accumulator: TERMS must be >= 1");
  end

  localparam int TW    = (clog2(TERMS) > 0) ? clog2(TERMS) : 1;
  localparam int SUM_W = ACC_W + 1;
  localparam logic [TW-1:0] LAST_TERM = TW'(TERMS - 1);

  state_t           state, state_nxt;
  logic             start;
  logic             mul_busy;
  logic             mul_done;
  logic [2*N-1:0]   product;
  logic [ACC_W-1:0] acc;
  logic             ovf_r;
  logic [TW-1:0]    term;
  logic [SUM_W-1:0] acc_sum;

  shift_add_mul #(.N(N)) u_mul (
    .clk     (clk),
    .rst     (rst),
    .start   (start),
    .x       (bus.x),
    .y       (bus.y),
    .busy    (mul_busy),
    .done    (mul_done),
    .product (product)
  );

  // Extra top bit captures the carry out of the modulo-2^ACC_W accumulator.
  assign acc_sum = {1'b0, acc} + SUM_W'(product);

  always_comb begin
    state_nxt = state;
    start     = 1'b0;
    case (state)
      IDLE: if (bus.in_valid && !mul_busy) begin
        start     = 1'b1;
        state_nxt = MUL;
      end
      MUL:  if (mul_done) state_nxt = ACC;
      ACC:  state_nxt = (term == LAST_TERM) ? OUT : IDLE;
      OUT:  if (bus.out_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      acc   <= '0;
      ovf_r <= 1'b0;
      term  <= '0;
    end else begin
      state <= state_nxt;
      if (state == ACC) begin
        acc   <= acc_sum[ACC_W-1:0];
        ovf_r <= ovf_r | acc_sum[ACC_W];
        if (term != LAST_TERM) term <= term + TW'(1);
      end else if (state == OUT && bus.out_ready) begin
        acc   <= '0;
        ovf_r <= 1'b0;
        term  <= '0;
      end
    end
  end

  assign bus.in_ready  = (state == IDLE);
  assign bus.out_valid = (state == OUT);
  assign bus.acc_out   = acc;
  assign bus.ovf       = ovf_r;

endmodule
